button_conditioner: RTL and testbench

//  Input-conditioning stage directly upstream of the processor io_jump input and the VGAController button inputs.

---
 rtl/button_conditioner.sv | 108 ++++++++++
 tb/tb_button_conditioner.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/button_conditioner.sv
// Per-button synchronizer, debouncer, press pulse and frame-sticky press flag.
// Define BTN_AUTOREPEAT_EN to re-emit btn_press every REPEAT_CYCLES while a button is held.
module button_conditioner #(
    parameter int NUM_BTN         = 4,
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int REPEAT_CYCLES   = 25000000,
    parameter int CNT_W           = 25
) (
    input  logic               clock,
    input  logic               reset,
    input  logic [NUM_BTN-1:0] btn_raw,
    input  logic               frame_ack,
    output logic [NUM_BTN-1:0] btn_level,
    output logic [NUM_BTN-1:0] btn_press,
    output logic [NUM_BTN-1:0] btn_latched
);

    if (DEBOUNCE_CYCLES < 1 || REPEAT_CYCLES < 1 ||
        DEBOUNCE_CYCLES > (2 ** CNT_W) - 1 || REPEAT_CYCLES > (2 ** CNT_W) - 1) begin : gBadParam
        $error("button_conditioner: DEBOUNCE_CYCLES/REPEAT_CYCLES out of range for CNT_W");
    end

    localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [NUM_BTN-1:0]            sync1_q;
    logic [NUM_BTN-1:0]            sync2_q;
    logic [NUM_BTN-1:0]            level_q, level_d;
    logic [NUM_BTN-1:0]            press_q, press_d;
    logic [NUM_BTN-1:0]            latched_q, latched_d;
    logic [NUM_BTN-1:0][CNT_W-1:0] debCnt_q, debCnt_d;
    logic [NUM_BTN-1:0]            repFire;

    // The level only moves after DEBOUNCE_CYCLES consecutive disagreeing samples.
    always_comb begin
        level_d  = level_q;
        debCnt_d = debCnt_q;
        for (int i = 0; i < NUM_BTN; i++) begin
            if (sync2_q[i] == level_q[i]) begin
                debCnt_d[i] = '0;
            end else if (debCnt_q[i] >= DEB_LAST) begin
                level_d[i]  = sync2_q[i];
                debCnt_d[i] = '0;
            end else begin
                debCnt_d[i] = debCnt_q[i] + CNT_W'(1);
            end
        end
    end

`ifdef BTN_AUTOREPEAT_EN
    localparam logic [CNT_W-1:0] REP_LAST = CNT_W'(REPEAT_CYCLES - 1);

    logic [NUM_BTN-1:0][CNT_W-1:0] repCnt_q, repCnt_d;

    // Counter restarts on the rising edge of the level and fires each time it wraps.
    always_comb begin
        repCnt_d = '0;
        repFire  = '0;
        for (int i = 0; i < NUM_BTN; i++) begin
            if (level_q[i] && level_d[i]) begin
                if (repCnt_q[i] >= REP_LAST) begin
                    repFire[i]  = 1'b1;
                    repCnt_d[i] = '0;
                end else begin
                    repCnt_d[i] = repCnt_q[i] + CNT_W'(1);
                end
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            repCnt_q <= '0;
        end else begin
            repCnt_q <= repCnt_d;
        end
    end
`else
    assign repFire = '0;
`endif

    always_comb begin
        press_d   = (level_d & ~level_q) | repFire;
        latched_d = press_q | (latched_q & ~{NUM_BTN{frame_ack}});
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sync1_q   <= '0;
            sync2_q   <= '0;
            level_q   <= '0;
            press_q   <= '0;
            latched_q <= '0;
            debCnt_q  <= '0;
        end else begin
            sync1_q   <= btn_raw;
            sync2_q   <= sync1_q;
            level_q   <= level_d;
            press_q   <= press_d;
            latched_q <= latched_d;
            debCnt_q  <= debCnt_d;
        end
    end

    assign btn_level   = level_q;
    assign btn_press   = press_q;
    assign btn_latched = latched_q;

endmodule

// File: tb/tb_button_conditioner.sv
// Self-checking bench for button_conditioner: directed scenarios with literal expectations,
// then randomized stimulus compared every cycle against a history-based behavioural model.
module tb_button_conditioner;

    localparam int NUM_BTN = 4;
    localparam int DEB     = 4;
    localparam int REP     = 8;
    localparam int CNTW    = 4;

    logic               clock = 1'b0;
    logic               reset;
    logic [NUM_BTN-1:0] btn_raw;
    logic               frame_ack;
    logic [NUM_BTN-1:0] btn_level;
    logic [NUM_BTN-1:0] btn_press;
    logic [NUM_BTN-1:0] btn_latched;

    int checks = 0;
    int errors = 0;

    button_conditioner #(
        .NUM_BTN         (NUM_BTN),
        .DEBOUNCE_CYCLES (DEB),
        .REPEAT_CYCLES   (REP),
        .CNT_W           (CNTW)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .btn_raw     (btn_raw),
        .frame_ack   (frame_ack),
        .btn_level   (btn_level),
        .btn_press   (btn_press),
        .btn_latched (btn_latched)
    );

    always #5 clock = ~clock;

    // Reference model: the synchronized value seen at edge n is the raw value sampled two
    // edges earlier; a level flips once the last DEB synchronized samples all disagree with it.
    logic [NUM_BTN-1:0] rawQ[$];
    logic [NUM_BTN-1:0] s2Q[$];
    logic [NUM_BTN-1:0] mLevel   = '0;
    logic [NUM_BTN-1:0] mPress   = '0;
    logic [NUM_BTN-1:0] mLatched = '0;
    logic [NUM_BTN-1:0] s2Seen;
    logic [NUM_BTN-1:0] newLevel;
    logic [NUM_BTN-1:0] newPress;
    logic               allDiffer;
    int                 edgeN = 0;
    int                 riseEdge[NUM_BTN];

    always @(posedge clock or posedge reset) begin
        if (reset) begin
            edgeN = 0;
            rawQ.delete();
            s2Q.delete();
            mLevel   = '0;
            mPress   = '0;
            mLatched = '0;
            foreach (riseEdge[i]) riseEdge[i] = 0;
        end else begin
            edgeN++;
            s2Seen = (rawQ.size() >= 2) ? rawQ[1] : '0;
            rawQ.push_front(btn_raw);
            if (rawQ.size() > 2) void'(rawQ.pop_back());
            s2Q.push_front(s2Seen);
            if (s2Q.size() > DEB) void'(s2Q.pop_back());
            newLevel = mLevel;
            for (int i = 0; i < NUM_BTN; i++) begin
                allDiffer = (s2Q.size() == DEB);
                for (int j = 0; j < s2Q.size(); j++)
                    if (s2Q[j][i] == mLevel[i]) allDiffer = 1'b0;
                if (allDiffer) newLevel[i] = ~mLevel[i];
            end
            newPress = '0;
            for (int i = 0; i < NUM_BTN; i++) begin
                if (newLevel[i] && !mLevel[i]) begin
                    riseEdge[i] = edgeN;
                    newPress[i] = 1'b1;
                end
`ifdef BTN_AUTOREPEAT_EN
                else if (newLevel[i] && mLevel[i] && ((edgeN - riseEdge[i]) % REP == 0)) begin
                    newPress[i] = 1'b1;
                end
`endif
            end
            mLatched = mPress | (mLatched & ~{NUM_BTN{frame_ack}});
            mPress   = newPress;
            mLevel   = newLevel;
        end
    end

    // Every falling edge the DUT outputs must equal the model.
    always @(negedge clock) begin
        checks++;
        if (btn_level !== mLevel) begin
            errors++;
            $display("[TB] FAIL cmp_level t=%0t got %b want %b", $time, btn_level, mLevel);
        end
        checks++;
        if (btn_press !== mPress) begin
            errors++;
            $display("[TB] FAIL cmp_press t=%0t got %b want %b", $time, btn_press, mPress);
        end
        checks++;
        if (btn_latched !== mLatched) begin
            errors++;
            $display("[TB] FAIL cmp_latched t=%0t got %b want %b", $time, btn_latched, mLatched);
        end
    end

    task automatic checkOutput(input string name, input logic [NUM_BTN-1:0] actual,
                               input logic [NUM_BTN-1:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s got %b want %b", name, actual, expected);
        end
    endtask

    // Drives inputs at a falling edge, then advances n rising edges to the following falling edge.
    task automatic applyStimulus(input logic [NUM_BTN-1:0] raw, input logic ack, input int n);
        btn_raw   = raw;
        frame_ack = ack;
        repeat (n) @(negedge clock);
    endtask

    task automatic resetPulse();
        #1;
        reset     = 1'b1;
        btn_raw   = '0;
        frame_ack = 1'b0;
        @(negedge clock);
        @(negedge clock);
        reset = 1'b0;
    endtask

    int                 pulseCount;
    int                 firstPulse;
    int                 flipRate;
    logic [NUM_BTN-1:0] r;

    initial begin
        reset     = 1'b1;
        btn_raw   = '0;
        frame_ack = 1'b0;
        @(negedge clock);

        // Scenario 1: outputs stay 0 under reset, then all four buttons rise together.
        applyStimulus(4'hF, 1'b0, 20);
        checkOutput("rst_level", btn_level, 4'h0);
        checkOutput("rst_press", btn_press, 4'h0);
        checkOutput("rst_latched", btn_latched, 4'h0);
        reset = 1'b0;
        applyStimulus(4'hF, 1'b0, 5);
        checkOutput("s1_level_e5", btn_level, 4'h0);
        applyStimulus(4'hF, 1'b0, 1);
        checkOutput("s1_level_e6", btn_level, 4'hF);
        checkOutput("s1_press_e6", btn_press, 4'hF);
        applyStimulus(4'hF, 1'b0, 1);
        checkOutput("s1_press_e7", btn_press, 4'h0);
        checkOutput("s1_latched_e7", btn_latched, 4'hF);

        // Scenario 2: single press on bit 0.
        resetPulse();
        checkOutput("s2_rst_level", btn_level, 4'h0);
        applyStimulus(4'b0001, 1'b0, 5);
        checkOutput("s2_level_e5", btn_level, 4'b0000);
        applyStimulus(4'b0001, 1'b0, 1);
        checkOutput("s2_level_e6", btn_level, 4'b0001);
        checkOutput("s2_press_e6", btn_press, 4'b0001);
        applyStimulus(4'b0001, 1'b0, 1);
        checkOutput("s2_press_e7", btn_press, 4'b0000);
        checkOutput("s2_latched_e7", btn_latched, 4'b0001);
        applyStimulus(4'b0001, 1'b0, 4);
        checkOutput("s2_latched_hold", btn_latched, 4'b0001);

        // Scenario 4a: frame_ack clears the sticky flag.
        applyStimulus(4'b0001, 1'b1, 1);
        checkOutput("s4_ack_clear", btn_latched, 4'b0000);

        // Scenario 3: 3-cycle glitch on bit 1 is rejected, a 6-cycle press is accepted.
        applyStimulus(4'b0011, 1'b0, 3);
        applyStimulus(4'b0001, 1'b0, 8);
        checkOutput("s3_glitch_level", btn_level, 4'b0001);
        checkOutput("s3_glitch_latched", btn_latched, 4'b0000);
        applyStimulus(4'b0011, 1'b0, 6);
        checkOutput("s3_level_e6", btn_level, 4'b0011);
        checkOutput("s3_press_e6", btn_press, 4'b0010);
        applyStimulus(4'b0001, 1'b0, 1);
        checkOutput("s3_latched", btn_latched, 4'b0010);

        // Scenario 4b: frame_ack in the same cycle as a press keeps the press.
        applyStimulus(4'b0001, 1'b0, 8);
        checkOutput("s4_level_settle", btn_level, 4'b0001);
        applyStimulus(4'b0101, 1'b0, 6);
        checkOutput("s4_press2", btn_press, 4'b0100);
        applyStimulus(4'b0101, 1'b1, 1);
        checkOutput("s4_set_wins", btn_latched, 4'b0100);
        applyStimulus(4'b0101, 1'b0, 1);
        checkOutput("s4_set_hold", btn_latched, 4'b0100);

        // Scenario 5: release gives no pulse; reset mid-count discards the count.
        applyStimulus(4'b0100, 1'b0, 5);
        checkOutput("s5_level_e5", btn_level, 4'b0101);
        applyStimulus(4'b0100, 1'b0, 1);
        checkOutput("s5_level_e6", btn_level, 4'b0100);
        checkOutput("s5_no_press", btn_press, 4'b0000);
        applyStimulus(4'b0000, 1'b0, 4);
        resetPulse();
        checkOutput("s5_rst_level", btn_level, 4'b0000);
        applyStimulus(4'b0000, 1'b0, 10);
        checkOutput("s5_after_level", btn_level, 4'b0000);
        checkOutput("s5_after_press", btn_press, 4'b0000);

        // Scenario 6: bit 3 held for 31 edges.
        resetPulse();
        pulseCount = 0;
        firstPulse = -1;
        for (int e = 1; e <= 31; e++) begin
            applyStimulus(4'b1000, 1'b0, 1);
            if (btn_press[3]) begin
                pulseCount++;
                if (firstPulse < 0) firstPulse = e;
            end
        end
        checks++;
        if (firstPulse != 6) begin
            errors++;
            $display("[TB] FAIL s6_first_pulse got %0d want 6", firstPulse);
        end
        checks++;
`ifdef BTN_AUTOREPEAT_EN
        if (pulseCount != 4) begin
            errors++;
            $display("[TB] FAIL s6_pulse_count got %0d want 4", pulseCount);
        end
`else
        if (pulseCount != 1) begin
            errors++;
            $display("[TB] FAIL s6_pulse_count got %0d want 1", pulseCount);
        end
`endif

        // Randomized phase: bouncy and steady stretches, random acks, occasional resets.
        r = '0;
        for (int c = 0; c < 3000; c++) begin
            flipRate = ((c / 400) % 2 == 0) ? 5 : 25;
            if ($urandom_range(0, 299) == 0) begin
                resetPulse();
                r = '0;
            end else begin
                for (int b = 0; b < NUM_BTN; b++)
                    if ($urandom_range(0, flipRate - 1) == 0) r[b] = ~r[b];
                applyStimulus(r, ($urandom_range(0, 7) == 0), 1);
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
